// File: rtl/mips_fetch_mem_unit_pkg.sv
// Shared constants for the multicycle MIPS front end: opcode/funct values,
// memory-port FSM encodings and instruction field helpers.
package mips_fetch_mem_unit_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_JR    = 6'h08;

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StWait = 1'b1;

  function automatic logic [5:0] op_field(input logic [31:0] ir);
    return ir[31:26];
  endfunction

  function automatic logic [5:0] funct_field(input logic [31:0] ir);
    return ir[5:0];
  endfunction

endpackage

// File: rtl/mips_fetch_mem_unit_mem_port_fsm.sv
// IDLE/WAIT handshake for the single shared memory port; generates mem_req,
// stall, and the capture/complete strobes used by the datapath.
module mem_port_fsm
  import mips_fetch_mem_unit_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic access,
  input  logic mem_ready,
  output logic mem_req,
  output logic stall,
  output logic complete,
  output logic capture,
  output logic in_wait
);

  logic [0:0] state_q, state_d;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (access && !mem_ready) state_d = StWait;
      StWait:  if (mem_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  assign in_wait  = (state_q == StWait);
  assign mem_req  = in_wait | access;
  assign stall    = mem_req & ~mem_ready;
  assign complete = mem_req & mem_ready;
  // Access request attributes are latched on the cycle we enter WAIT.
  assign capture  = ~in_wait & access & ~mem_ready;

endmodule

// File: rtl/mips_fetch_mem_unit.sv
// Multicycle MIPS datapath front end: PC, IR and MDR, next-PC and memory
// address selection, driven directly by the control FSM's strobes.
module mips_fetch_mem_unit
  import mips_fetch_mem_unit_pkg::*;
#(
  parameter int unsigned       WIDTH    = 32,
  parameter logic [WIDTH-1:0]  RESET_PC = WIDTH'(32'h0040_0000)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             PC_Write,
  input  logic             Branch,
  input  logic             PC_Src,
  input  logic             PC_J,
  input  logic             IorD,
  input  logic             IR_Write,
  input  logic             Mem_Write,
  input  logic [WIDTH-1:0] alu_result,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             zero,
  input  logic [WIDTH-1:0] reg_b,
  input  logic [WIDTH-1:0] mem_rdata,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  output logic             stall,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] instr,
  output logic [WIDTH-1:0] mdr,
  output logic [5:0]       Op,
  output logic [5:0]       Funct,
  output logic [4:0]       rs,
  output logic [4:0]       rt,
  output logic [4:0]       rd,
  output logic [15:0]      imm
);

  logic             access, complete, capture, in_wait;
  logic [WIDTH-1:0] pc_q, ir_q, mdr_q, addr_q;
  logic             we_q, ir_wr_q, mdr_wr_q;
  logic [WIDTH-1:0] addr_sel, pc_next;
  logic             we_sel, ir_wr_sel, mdr_wr_sel, pc_en;

  assign access = IR_Write | Mem_Write | IorD;

  mem_port_fsm u_mem_port_fsm (
    .clk       (clk),
    .rst       (rst),
    .access    (access),
    .mem_ready (mem_ready),
    .mem_req   (mem_req),
    .stall     (stall),
    .complete  (complete),
    .capture   (capture),
    .in_wait   (in_wait)
  );

  // While waiting, the port presents the attributes captured at request time.
  assign addr_sel   = in_wait ? addr_q   : (IorD ? alu_out : pc_q);
  assign we_sel     = in_wait ? we_q     : Mem_Write;
  assign ir_wr_sel  = in_wait ? ir_wr_q  : IR_Write;
  assign mdr_wr_sel = in_wait ? mdr_wr_q : (IorD & ~Mem_Write);

  assign mem_addr  = addr_sel;
  assign mem_we    = we_sel & mem_req;
  assign mem_wdata = reg_b;

  // PC_Write dominates Branch simply by OR-ing; jump target uses the current IR.
  assign pc_en = (PC_Write | (Branch & zero)) & ~stall;

  always_comb begin
    pc_next = alu_result;
    if (PC_Src) begin
      if (PC_J) pc_next = alu_out;
      else      pc_next = {pc_q[WIDTH-1:28], ir_q[25:0], 2'b00};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q     <= RESET_PC;
      ir_q     <= '0;
      mdr_q    <= '0;
      addr_q   <= '0;
      we_q     <= 1'b0;
      ir_wr_q  <= 1'b0;
      mdr_wr_q <= 1'b0;
    end else begin
      if (pc_en) pc_q <= pc_next;
      if (complete && ir_wr_sel) ir_q <= mem_rdata;
      if (complete && mdr_wr_sel) mdr_q <= mem_rdata;
      if (capture) begin
        addr_q   <= addr_sel;
        we_q     <= we_sel;
        ir_wr_q  <= ir_wr_sel;
        mdr_wr_q <= mdr_wr_sel;
      end
    end
  end

  assign pc    = pc_q;
  assign instr = ir_q;
  assign mdr   = mdr_q;
  assign Op    = op_field(ir_q[31:0]);
  assign Funct = funct_field(ir_q[31:0]);
  assign rs    = ir_q[25:21];
  assign rt    = ir_q[20:16];
  assign rd    = ir_q[15:11];
  assign imm   = ir_q[15:0];

endmodule

// File: tb/tb_mips_fetch_mem_unit.sv
// Self-checking bench for mips_fetch_mem_unit: expected PC/IR/MDR states are
// queued as stimulus is driven and compared after the clock edge.
module tb_mips_fetch_mem_unit;

  localparam logic [31:0] RESET_PC = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        PC_Write, Branch, PC_Src, PC_J, IorD, IR_Write, Mem_Write, zero;
  logic [31:0] alu_result, alu_out, reg_b, mem_rdata;
  logic        mem_ready;
  logic        mem_req, mem_we, stall;
  logic [31:0] mem_addr, mem_wdata, pc, instr, mdr;
  logic [5:0]  Op, Funct;
  logic [4:0]  rs, rt, rd;
  logic [15:0] imm;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] mdr;
  } state_t;

  state_t sb[$];
  state_t exp_s;
  logic [31:0] pc_m, instr_m, mdr_m;
  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mips_fetch_mem_unit dut (
    .clk        (clk),
    .rst        (rst),
    .PC_Write   (PC_Write),
    .Branch     (Branch),
    .PC_Src     (PC_Src),
    .PC_J       (PC_J),
    .IorD       (IorD),
    .IR_Write   (IR_Write),
    .Mem_Write  (Mem_Write),
    .alu_result (alu_result),
    .alu_out    (alu_out),
    .zero       (zero),
    .reg_b      (reg_b),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .stall      (stall),
    .pc         (pc),
    .instr      (instr),
    .mdr        (mdr),
    .Op         (Op),
    .Funct      (Funct),
    .rs         (rs),
    .rt         (rt),
    .rd         (rd),
    .imm        (imm)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    PC_Write = 0; Branch = 0; PC_Src = 0; PC_J = 0; IorD = 0; IR_Write = 0;
    Mem_Write = 0; zero = 0; alu_result = '0; alu_out = '0; reg_b = '0;
    mem_rdata = '0; mem_ready = 1'b1;
  endtask

  task automatic push_exp(input logic [31:0] p, input logic [31:0] i, input logic [31:0] m);
    sb.push_back('{pc: p, instr: i, mdr: m});
    pc_m = p; instr_m = i; mdr_m = m;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1;
    tick(); tick();
    rst = 0;
    #1;
    push_exp(RESET_PC, 32'h0, 32'h0);
    exp_s = sb.pop_front();
    vectors++;
    if ({pc, instr, mdr} !== exp_s) begin
      miscompares++;
      $display("FAIL reset_regs: got pc=%h instr=%h mdr=%h want pc=%h instr=%h mdr=%h",
               pc, instr, mdr, exp_s.pc, exp_s.instr, exp_s.mdr);
    end
    vectors++;
    if ({mem_req, stall} !== 2'b00) begin
      miscompares++;
      $display("FAIL reset_port: got mem_req=%b stall=%b want 0 0", mem_req, stall);
    end
  endtask

  task automatic test_fetch();
    PC_Write = 1; IR_Write = 1; alu_result = pc_m + 32'd4;
    mem_ready = 1; mem_rdata = 32'h2008_0005;
    #1;
    vectors++;
    if ({mem_req, stall, mem_we, mem_addr} !== {3'b100, pc_m}) begin
      miscompares++;
      $display("FAIL fetch_port: got req=%b stall=%b we=%b addr=%h want 1 0 0 %h",
               mem_req, stall, mem_we, mem_addr, pc_m);
    end
    push_exp(32'h0040_0004, 32'h2008_0005, mdr_m);
    tick();
    idle_inputs();
    exp_s = sb.pop_front();
    vectors++;
    if ({pc, instr, mdr} !== exp_s) begin
      miscompares++;
      $display("FAIL fetch_regs: got pc=%h instr=%h mdr=%h want pc=%h instr=%h mdr=%h",
               pc, instr, mdr, exp_s.pc, exp_s.instr, exp_s.mdr);
    end
    vectors++;
    if ({Op, rs, rt, imm, Funct} !== {6'h08, 5'd0, 5'd8, 16'h0005, 6'h05}) begin
      miscompares++;
      $display("FAIL fetch_fields: got Op=%h rs=%0d rt=%0d imm=%h Funct=%h want 08 0 8 0005 05",
               Op, rs, rt, imm, Funct);
    end
  endtask

  task automatic test_stall_fetch();
    logic [31:0] pc0, ir0;
    pc0 = pc_m; ir0 = instr_m;
    PC_Write = 1; IR_Write = 1; alu_result = pc_m + 32'd4;
    mem_ready = 0; mem_rdata = 32'hFFFF_FFFF;
    push_exp(pc0 + 32'd4, 32'h0810_0010, mdr_m);
    for (int i = 0; i < 3; i++) begin
      #1;
      vectors++;
      if ({stall, mem_req, mem_addr} !== {2'b11, pc0}) begin
        miscompares++;
        $display("FAIL stall_port[%0d]: got stall=%b req=%b addr=%h want 1 1 %h",
                 i, stall, mem_req, mem_addr, pc0);
      end
      tick();
      vectors++;
      if ({pc, instr} !== {pc0, ir0}) begin
        miscompares++;
        $display("FAIL stall_hold[%0d]: got pc=%h instr=%h want pc=%h instr=%h",
                 i, pc, instr, pc0, ir0);
      end
    end
    mem_ready = 1; mem_rdata = 32'h0810_0010;
    #1;
    vectors++;
    if ({stall, mem_req} !== 2'b01) begin
      miscompares++;
      $display("FAIL stall_release: got stall=%b req=%b want 0 1", stall, mem_req);
    end
    tick();
    idle_inputs();
    exp_s = sb.pop_front();
    vectors++;
    if ({pc, instr, mdr} !== exp_s) begin
      miscompares++;
      $display("FAIL stall_load: got pc=%h instr=%h mdr=%h want pc=%h instr=%h mdr=%h",
               pc, instr, mdr, exp_s.pc, exp_s.instr, exp_s.mdr);
    end
  endtask

  task automatic test_jump();
    PC_Write = 1; PC_Src = 1; PC_J = 0;
    alu_result = 32'hBAD0_0000; alu_out = 32'hBAD1_0000;
    push_exp(32'h0040_0040, instr_m, mdr_m);
    tick();
    idle_inputs();
    exp_s = sb.pop_front();
    vectors++;
    if (pc !== exp_s.pc) begin
      miscompares++;
      $display("FAIL jump_pc: got %h want %h", pc, exp_s.pc);
    end
  endtask

  task automatic test_branch();
    logic [31:0] pcs [3];
    logic [2:0]  ctl [3];  // {PC_Write, zero, unused}
    logic [31:0] tgt [3];
    pcs[0] = 32'h0040_0020; ctl[0] = 3'b010; tgt[0] = 32'h0040_0020;
    pcs[1] = 32'h0040_0020; ctl[1] = 3'b000; tgt[1] = 32'h0040_0080;
    pcs[2] = 32'h0040_0080; ctl[2] = 3'b100; tgt[2] = 32'h0040_0080;
    for (int i = 0; i < 3; i++) begin
      Branch = 1; PC_Src = 1; PC_J = 1;
      PC_Write = ctl[i][2]; zero = ctl[i][1]; alu_out = tgt[i];
      alu_result = 32'hDEAD_0000;
      push_exp(pcs[i], instr_m, mdr_m);
      tick();
      idle_inputs();
      exp_s = sb.pop_front();
      vectors++;
      if (pc !== exp_s.pc) begin
        miscompares++;
        $display("FAIL branch_pc[%0d]: got %h want %h", i, pc, exp_s.pc);
      end
    end
  endtask

  task automatic test_store_load();
    Mem_Write = 1; IorD = 1; alu_out = 32'h1001_0000; reg_b = 32'hDEAD_BEEF;
    mem_ready = 1; mem_rdata = 32'h5555_5555;
    #1;
    vectors++;
    if ({mem_req, mem_we, stall, mem_addr, mem_wdata} !==
        {3'b110, 32'h1001_0000, 32'hDEAD_BEEF}) begin
      miscompares++;
      $display("FAIL sw_port: got req=%b we=%b stall=%b addr=%h wdata=%h want 1 1 0 10010000 deadbeef",
               mem_req, mem_we, stall, mem_addr, mem_wdata);
    end
    push_exp(pc_m, instr_m, mdr_m);
    tick();
    idle_inputs();
    exp_s = sb.pop_front();
    vectors++;
    if ({pc, instr, mdr} !== exp_s) begin
      miscompares++;
      $display("FAIL sw_regs: got pc=%h instr=%h mdr=%h want pc=%h instr=%h mdr=%h",
               pc, instr, mdr, exp_s.pc, exp_s.instr, exp_s.mdr);
    end
    IorD = 1; alu_out = 32'h1001_0000; mem_ready = 0; mem_rdata = 32'hFFFF_FFFF;
    push_exp(pc_m, instr_m, 32'h0000_1234);
    #1;
    vectors++;
    if ({mem_we, stall, mem_addr} !== {2'b01, 32'h1001_0000}) begin
      miscompares++;
      $display("FAIL lw_wait: got we=%b stall=%b addr=%h want 0 1 10010000", mem_we, stall, mem_addr);
    end
    tick();
    alu_out = 32'h2222_0000;
    #1;
    vectors++;
    if (mem_addr !== 32'h1001_0000) begin
      miscompares++;
      $display("FAIL lw_addr_frozen: got %h want 10010000", mem_addr);
    end
    mem_ready = 1; mem_rdata = 32'h0000_1234;
    tick();
    idle_inputs();
    exp_s = sb.pop_front();
    vectors++;
    if ({pc, instr, mdr} !== exp_s) begin
      miscompares++;
      $display("FAIL lw_regs: got pc=%h instr=%h mdr=%h want pc=%h instr=%h mdr=%h",
               pc, instr, mdr, exp_s.pc, exp_s.instr, exp_s.mdr);
    end
  endtask

  task automatic test_reset_in_wait();
    PC_Write = 1; IR_Write = 1; alu_result = 32'h1111_0000; mem_ready = 0;
    tick();
    rst = 1; mem_ready = 1; mem_rdata = 32'h7777_7777;
    push_exp(RESET_PC, 32'h0, 32'h0);
    tick();
    idle_inputs();
    rst = 0;
    #1;
    exp_s = sb.pop_front();
    vectors++;
    if ({pc, instr, mdr} !== exp_s) begin
      miscompares++;
      $display("FAIL rst_wait_regs: got pc=%h instr=%h mdr=%h want pc=%h instr=%h mdr=%h",
               pc, instr, mdr, exp_s.pc, exp_s.instr, exp_s.mdr);
    end
    vectors++;
    if ({mem_req, stall} !== 2'b00) begin
      miscompares++;
      $display("FAIL rst_wait_port: got req=%b stall=%b want 0 0", mem_req, stall);
    end
  endtask

  initial begin
    rst = 1;
    idle_inputs();
    test_reset();
    test_fetch();
    test_stall_fetch();
    test_jump();
    test_branch();
    test_store_load();
    test_reset_in_wait();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
